uart_rx: RTL
============

# uart_rx

Configurable UART receiver: the downstream counterpart of the team's UART transmitter. Oversamples the serial line on a shared baud-rate tick, reframes start/data/parity/stop bits, and presents a zero-extended parallel word with a one-cycle valid strobe and per-frame error flags. Its configuration word and frame format match the transmitter, so a TX→RX loopback with identical config is lossless.

## Interface
- OVERSAMPLE, 16, ticks of i_uart_clk_enable per bit period. Must be even and ≥4.
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous, active-low reset
- i_config  in  7  [6]=stop bits (0=1, 1=2), [5]=parity enable, [4:1]=word size (clamped to [5,9]), [0]=store strobe
- i_uart_clk_enable  in  1  single-cycle oversample tick at OVERSAMPLE×baud
- i_rx  in  1  asynchronous serial line, idle high
- o_rx_parallel  out  9  received word, LSB = first data bit, bits ≥ word size are 0
- o_rx_valid  out  1  one-cycle strobe: o_rx_parallel and error flags are updated
- o_parity_error  out  1  parity mismatch on last frame
- o_frame_error  out  1  a stop bit sampled low on last frame
- o_ready  out  1  high in IDLE; config is accepted only then

## Operation
- i_rx passes through a 2-flop synchronizer (reset value 1) plus one edge-history flop. All decisions use the synchronized value.
- Config reset defaults: word size 8, parity enabled, 1 stop bit. Config is stored when i_config[0]=1 in IDLE with no start edge that cycle. Word size <5 → 5; >9 → 9. A start edge takes priority over a config store in the same cycle.
- States:
  - IDLE: o_ready=1. A falling edge (history 1, current 0) clears the tick counter and moves to START.
  - START: at tick OVERSAMPLE/2, sample. If 1, treat as a glitch and return to IDLE with no strobe. If 0, clear the counter and enter DATA.
  - DATA: sample every OVERSAMPLE ticks into bit index idx, starting from 0. After idx = word_size−1, go to PARITY if parity is enabled, else STOP.
  - PARITY: take one sample. Parity error = XOR(received data bits, parity bit) ≠ 0, i.e. even parity where the parity bit equals the XOR of the data bits.
  - STOP: take one sample per configured stop bit (1 or 2). Any low sample sets a frame error.
  - DONE: one cycle. Updates o_rx_parallel, o_parity_error and o_frame_error, pulses o_rx_valid, then returns to IDLE.
- Data is delivered even when errors are flagged. Error flags hold until the next o_rx_valid.
- When parity is disabled, o_parity_error is 0.
- A line held low (break) yields frame error = 1 and data 0. A new frame needs a fresh 1→0 edge, so a break never retriggers reception.
- Config changes never affect a frame in flight. Latched config is used for the whole frame.

## Timing
- Reset values: o_rx_parallel=0, o_rx_valid=0, o_parity_error=0, o_frame_error=0, o_ready=0 during reset and 1 from the first cycle after reset.
- The tick counter advances only on i_uart_clk_enable. All sample points fall at the centre of the bit (tick OVERSAMPLE/2 within the bit period).
- o_rx_valid rises on the clock after the final stop-bit sample cycle and lasts exactly one cycle.
- o_ready falls on the cycle after the start edge is detected. It rises in the cycle after DONE.
- Reset mid-frame: return to IDLE immediately, drop the partial word, load default config, and clear the synchronizer to 1.
- Frame length in ticks is OVERSAMPLE × (1 + word_size + parity + stop bits). Sync latency is 2 clocks.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of samples at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1. This applies to the start, data, parity and stop bits, and the decision is taken at the third sample.
- UART_RX_MAJORITY_EN undefined: a single sample at tick OVERSAMPLE/2. This variant has no extra sample registers.
- Frame timing at the output strobe differs by one tick between the two variants. The bench must allow for this.

## Test plan
- Default config, serial 8'hA5 with even parity bit 0 and 1 stop bit → one o_rx_valid, o_rx_parallel=9'h0A5, both error flags 0.
- Config 7'b1_0_1001_1 (9 bits, no parity, 2 stop bits), send 9'h1C3 → 9'h1C3. Driving the second stop bit low instead → o_frame_error=1.
- Config with word size 3 → clamped to 5. Send 5'h15 → o_rx_parallel=9'h015 and bits 8:5 are 0.
- Parity enabled, data 8'h01 with parity bit 0 → o_parity_error=1 and data still 9'h001.
- Start glitch of 4 ticks low (OVERSAMPLE=16) → no o_rx_valid and o_ready back to 1. A 1-tick mid-bit glitch is absorbed only when UART_RX_MAJORITY_EN is defined.
- Assert reset during the data bits of one frame, then send 8'h3C → exactly one valid strobe, carrying 9'h03C.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with parity/stop checking; define UART_RX_MAJORITY_EN for 2-of-3 bit voting
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_config,
  input  logic       i_uart_clk_enable,
  input  logic       i_rx,
  output logic [8:0] o_rx_parallel,
  output logic       o_rx_valid,
  output logic       o_parity_error,
  output logic       o_frame_error,
  output logic       o_ready
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] PRESET = CW'(OVERSAMPLE / 2 - 1);
`else
  localparam logic [CW-1:0] PRESET = CW'(OVERSAMPLE / 2);
`endif
  if (OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0) begin : g_bad
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  state_t state, state_n;
  logic rx_meta, rx_sync, rx_prev;
  logic [3:0] cfg_ws, ws_in, idx;
  logic cfg_par, cfg_stop2, stop_idx;
  logic [CW-1:0] cnt;
  logic [8:0] shreg;
  logic par_acc, ferr_acc, bit_val, sample, start_edge, cfg_store;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge i_clk)
    if (!i_rst_n) hist <= 2'b11;
    else if (i_uart_clk_enable) hist <= {hist[0], rx_sync};
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
`else
  assign bit_val = rx_sync;
`endif
  always_ff @(posedge i_clk)
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_edge) state_n = START;
      START:   if (sample) state_n = bit_val ? IDLE : DATA;
      DATA:    if (sample && idx == cfg_ws - 4'd1) state_n = cfg_par ? PARITY : STOP;
      PARITY:  if (sample) state_n = STOP;
      STOP:    if (sample && (!cfg_stop2 || stop_idx)) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    o_ready = i_rst_n && state == IDLE;
    start_edge = state == IDLE && rx_prev && !rx_sync;
    cfg_store = state == IDLE && i_config[0] && !start_edge;
    sample = i_uart_clk_enable && cnt == LAST;
    ws_in = i_config[4:1] < 4'd5 ? 4'd5 : i_config[4:1] > 4'd9 ? 4'd9 : i_config[4:1];
  end
  // The counter is preset on the start edge so every decision lands on its wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      cfg_ws <= 4'd8;
      cfg_par <= 1'b1;
      cfg_stop2 <= 1'b0;
      cnt <= '0;
      idx <= '0;
      stop_idx <= 1'b0;
      shreg <= '0;
      par_acc <= 1'b0;
      ferr_acc <= 1'b0;
      o_rx_parallel <= '0;
      o_rx_valid <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      o_rx_valid <= 1'b0;
      if (cfg_store) begin
        cfg_ws <= ws_in;
        cfg_par <= i_config[5];
        cfg_stop2 <= i_config[6];
      end
      if (start_edge) begin
        cnt <= PRESET;
        idx <= '0;
        stop_idx <= 1'b0;
        shreg <= '0;
        par_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end else if (i_uart_clk_enable) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      if (sample)
        case (state)
          DATA: begin
            shreg[idx] <= bit_val;
            idx <= idx + 4'd1;
            par_acc <= par_acc ^ bit_val;
          end
          PARITY: par_acc <= par_acc ^ bit_val;
          STOP: begin
            stop_idx <= 1'b1;
            ferr_acc <= ferr_acc | ~bit_val;
          end
          default: ;
        endcase
      if (state == STOP && state_n == DONE) begin
        o_rx_parallel <= shreg;
        o_parity_error <= cfg_par & par_acc;
        o_frame_error <= ferr_acc | ~bit_val;
        o_rx_valid <= 1'b1;
      end
    end
  end
endmodule
